mod_bit_grouper: RTL
====================

# mod_bit_grouper

Serial-to-parallel bit grouper that sits directly upstream of the modulation-mapper LUTs in the PUSCH chain. It takes the scrambled bit stream one bit per cycle and collects Qm bits per symbol for the codeword's modulation order (pi/2-BPSK, QPSK, 16QAM, 64QAM, 256QAM). Each completed group is presented, with the matching one-hot LUT enable, to the mapper stage. It also handles codeword start/end framing, zero-pads a truncated final group, and counts emitted symbols.

## Interface
- MAX_QM, 8, width of the group bus in bits (largest supported Qm).
- CNT_WIDTH, 16, width of the symbol counter.

- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  synchronous, active-low reset.
- Start  input  1  one-cycle codeword start; latches Mod_Order; carries no data bit.
- Mod_Order  input  3  0=BPSK(Qm1), 1=QPSK(2), 2=16QAM(4), 3=64QAM(6), 4=256QAM(8); 5-7 invalid.
- Bit_In  input  1  serial data bit.
- Bit_Valid  input  1  Bit_In is valid this cycle.
- Last  input  1  qualifies the final bit of the codeword; honoured only with Bit_Valid.
- Group_Out  output  MAX_QM  collected bits, right-aligned; first-received bit at bit Qm-1; unused upper bits 0.
- Group_Valid  output  1  Group_Out valid; one-cycle pulse per symbol.
- EN_BPSK, EN_QPSK, EN_16QAM, EN_64QAM, EN_256QAM  output  1 each  one-hot LUT enable; asserted only with Group_Valid.
- Pad_Err  output  1  one-cycle pulse with the zero-padded final group.
- Cfg_Err  output  1  one-cycle pulse when Start arrives with an invalid Mod_Order.
- Busy  output  1  high while in COLLECT.
- Sym_Count  output  CNT_WIDTH  groups emitted in the current codeword.

## Operation
- States: IDLE, COLLECT.
- IDLE: Bit_Valid ignored. Start with a valid Mod_Order latches Qm, clears the bit counter, shift register and Sym_Count, and moves to COLLECT. Start with an invalid code pulses Cfg_Err and stays in IDLE.
- COLLECT, Bit_Valid=1: shift Bit_In into the LSB of the shift register and increment the bit counter.
- When the counter reaches Qm:
  - Register the group to Group_Out.
  - Pulse Group_Valid and the matching EN_*.
  - Increment Sym_Count, saturating at all-ones.
  - Reset the counter to 0.
- Last with Bit_Valid:
  - If this bit completes a group, emit normally.
  - Otherwise, left-shift the partial group with zeros to Qm bits, emit it, and pulse Pad_Err with it.
  - In both cases return to IDLE.
- Start while in COLLECT discards the partial group without emitting it. The new configuration is latched (invalid code: Cfg_Err, go to IDLE). Sym_Count is cleared.
- Start and Bit_Valid in the same cycle: Start wins, and the bit is dropped.
- Bit_Valid low: hold all state. Gaps between bits are allowed anywhere in a group.
- Sym_Count holds its value in IDLE until the next valid Start.

## Timing
- Reset values (RST low at an edge): state IDLE; Group_Out 0; Group_Valid, all EN_*, Pad_Err, Cfg_Err, Busy 0; Sym_Count 0; counter 0.
- Reset mid-codeword aborts it with no emission on the following cycle.
- Latency: Group_Valid/Group_Out/EN_* appear one cycle after the edge that samples the group's final bit.
- Group_Out holds its value until the next group. Strobes are single-cycle.
- Back-to-back: the QPSK maximum rate is one group every 2 cycles; BPSK gives one group per cycle.
- Cfg_Err: one cycle after the offending Start.
- Busy: rises the cycle after Start and falls the cycle after Last is sampled.
- No backpressure: the downstream mapper accepts every group.

## Test plan
- QPSK, Start then bits 1,0,0,1,1,1 continuous, Last on the 6th bit:
  - groups 2'b10, 2'b01, 2'b11 on cycles 2, 4, 6 after the first bit;
  - EN_QPSK pulses with each; Sym_Count ends at 3; Busy falls.
- 16QAM, bits 1,1,0,1 with 2-cycle gaps: exactly one Group_Out=8'h0D with EN_16QAM, one cycle after the 4th bit.
- 64QAM, Last on the 4th bit 1,0,1,1: Group_Out=8'h2C, Pad_Err=1, EN_64QAM=1; state IDLE.
- Start with Mod_Order=6: Cfg_Err pulse, no Busy. A subsequent Bit_Valid produces no output.
- 256QAM partial (5 bits), then Start with BPSK: no emission for the partial. Following bits 1,0 give two groups 8'h01, 8'h00 with EN_BPSK; Sym_Count=2.
- RST low mid-group (QPSK, 1 bit in): all outputs 0 next cycle. A later Start plus bits 0,0 gives Group_Out=0 with Group_Valid.

Source files
------------

// File: rtl/mod_bit_grouper_if.sv
// Bit-stream in / symbol-group out bundle between the scrambler and the mapper LUTs.
interface mod_bit_grouper_if #(
    parameter int MAX_QM    = 8,
    parameter int CNT_WIDTH = 16
);
    logic                 Start;
    logic [2:0]           Mod_Order;
    logic                 Bit_In;
    logic                 Bit_Valid;
    logic                 Last;
    logic [MAX_QM-1:0]    Group_Out;
    logic                 Group_Valid;
    logic                 EN_BPSK;
    logic                 EN_QPSK;
    logic                 EN_16QAM;
    logic                 EN_64QAM;
    logic                 EN_256QAM;
    logic                 Pad_Err;
    logic                 Cfg_Err;
    logic                 Busy;
    logic [CNT_WIDTH-1:0] Sym_Count;

    modport master (
        output Start, Mod_Order, Bit_In, Bit_Valid, Last,
        input  Group_Out, Group_Valid, EN_BPSK, EN_QPSK, EN_16QAM, EN_64QAM,
               EN_256QAM, Pad_Err, Cfg_Err, Busy, Sym_Count
    );

    modport slave (
        input  Start, Mod_Order, Bit_In, Bit_Valid, Last,
        output Group_Out, Group_Valid, EN_BPSK, EN_QPSK, EN_16QAM, EN_64QAM,
               EN_256QAM, Pad_Err, Cfg_Err, Busy, Sym_Count
    );
endinterface

// File: rtl/mod_bit_grouper.sv
// Collects Qm serial bits per symbol for the PUSCH mapper, with codeword framing,
// zero-padding of a truncated final group and a saturating symbol counter.
module mod_bit_grouper #(
    parameter int MAX_QM    = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic              CLK,
    input  logic              RST,
    mod_bit_grouper_if.slave  bus
);
    localparam int CW = $clog2(MAX_QM + 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, qm, qm_new, cnt_inc;
    logic [2:0]           mod_q;
    logic [MAX_QM-1:0]    sr, sr_shift;
    logic [MAX_QM-1:0]    group_q;
    logic                 gv_q, pad_q, cfg_q;
    logic [4:0]           en_q;
    logic [CNT_WIDTH-1:0] sym_q;
    logic                 cfg_ok, bit_take, grp_done, pad;

    always_comb begin
        qm_new = CW'(1);
        case (bus.Mod_Order)
            3'd0:    qm_new = CW'(1);
            3'd1:    qm_new = CW'(2);
            3'd2:    qm_new = CW'(4);
            3'd3:    qm_new = CW'(6);
            3'd4:    qm_new = CW'(8);
            default: qm_new = CW'(1);
        endcase
    end

    assign cfg_ok   = (bus.Mod_Order <= 3'd4);
    // Start has priority: a bit arriving with Start is dropped.
    assign bit_take = (state == COLLECT) && !bus.Start && bus.Bit_Valid;
    assign cnt_inc  = cnt + CW'(1);
    assign sr_shift = {sr[MAX_QM-2:0], bus.Bit_In};
    assign grp_done = bit_take && (cnt_inc == qm);
    assign pad      = bit_take && bus.Last && !grp_done;

    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.Start)
            state_nxt = cfg_ok ? COLLECT : IDLE;
        else if (bit_take && bus.Last)
            state_nxt = IDLE;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt     <= '0;
            qm      <= CW'(1);
            mod_q   <= '0;
            sr      <= '0;
            group_q <= '0;
            gv_q    <= 1'b0;
            pad_q   <= 1'b0;
            cfg_q   <= 1'b0;
            en_q    <= '0;
            sym_q   <= '0;
        end else begin
            gv_q  <= 1'b0;
            pad_q <= 1'b0;
            cfg_q <= 1'b0;
            en_q  <= '0;
            if (bus.Start) begin
                cnt <= '0;
                sr  <= '0;
                if (!cfg_ok) cfg_q <= 1'b1;
                else begin
                    qm    <= qm_new;
                    mod_q <= bus.Mod_Order;
                end
                // An invalid Start in IDLE leaves the previous codeword's count visible.
                if (cfg_ok || state == COLLECT) sym_q <= '0;
            end else if (bit_take) begin
                if (grp_done || bus.Last) begin
                    group_q <= grp_done ? sr_shift : (sr_shift << (qm - cnt_inc));
                    gv_q    <= 1'b1;
                    pad_q   <= pad;
                    en_q    <= 5'b00001 << mod_q;
                    if (sym_q != '1) sym_q <= sym_q + CNT_WIDTH'(1);
                    cnt     <= '0;
                    sr      <= '0;
                end else begin
                    cnt <= cnt_inc;
                    sr  <= sr_shift;
                end
            end
        end
    end

    assign bus.Group_Out   = group_q;
    assign bus.Group_Valid = gv_q;
    assign bus.EN_BPSK     = en_q[0];
    assign bus.EN_QPSK     = en_q[1];
    assign bus.EN_16QAM    = en_q[2];
    assign bus.EN_64QAM    = en_q[3];
    assign bus.EN_256QAM   = en_q[4];
    assign bus.Pad_Err     = pad_q;
    assign bus.Cfg_Err     = cfg_q;
    assign bus.Busy        = (state == COLLECT);
    assign bus.Sym_Count   = sym_q;
endmodule
